// File: rtl/cpu_phase_sequencer.sv
// ============================================================================
// Module   : cpu_phase_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK phase controller
//            with RAM wait states, halt, memory-timeout fault and retire count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cpu_phase_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             PRS,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       instr_class,
    input  logic             mem_ready,
    output logic [2:0]       phase,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_src,
    output logic             imm_sel,
    output logic             rf_we,
    output logic             ram_re,
    output logic             ram_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] c_cls_nop     = 3'd0;
    localparam logic [2:0] c_cls_alu_reg = 3'd1;
    localparam logic [2:0] c_cls_alu_imm = 3'd2;
    localparam logic [2:0] c_cls_load    = 3'd3;
    localparam logic [2:0] c_cls_store   = 3'd4;
    localparam logic [2:0] c_cls_branch  = 3'd5;
    localparam logic [2:0] c_cls_jump    = 3'd6;
    localparam logic [2:0] c_cls_halt    = 3'd7;

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        c_st_idle    = 3'd0,
        c_st_fetch   = 3'd1,
        c_st_decode  = 3'd2,
        c_st_execute = 3'd3,
        c_st_mem     = 3'd4,
        c_st_wb      = 3'd5,
        c_st_halted  = 3'd6,
        c_st_fault   = 3'd7
    } state_t;

    state_t           r_state;
    logic [2:0]       r_cls;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;

    // Output decode: Moore on state/cls, except the STORE retire strobe
    // which must coincide with the mem_ready cycle.
    always_comb begin
        ir_load = 1'b0;
        pc_en   = 1'b0;
        pc_src  = 1'b0;
        imm_sel = 1'b0;
        rf_we   = 1'b0;
        ram_re  = 1'b0;
        ram_we  = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        case (r_state)
            c_st_fetch: ir_load = 1'b1;
            c_st_execute: begin
                case (r_cls)
                    c_cls_nop, c_cls_jump: pc_en = 1'b1;
                    c_cls_branch: begin
                        pc_en  = 1'b1;
                        pc_src = 1'b1;
                    end
                    c_cls_alu_imm: imm_sel = 1'b1;
                    default: ;
                endcase
            end
            c_st_mem: begin
                ram_re = (r_cls == c_cls_load);
                ram_we = (r_cls == c_cls_store);
                pc_en  = (r_cls == c_cls_store) && mem_ready;
            end
            c_st_wb: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                imm_sel = (r_cls == c_cls_alu_imm);
            end
            c_st_halted: halted = 1'b1;
            c_st_fault:  fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (PRS) begin
            r_state   <= c_st_idle;
            r_cls     <= c_cls_nop;
            r_wait    <= 8'd0;
            r_retired <= '0;
        end else begin
            case (r_state)
                c_st_idle:   if (start) r_state <= c_st_fetch;
                c_st_fetch:  r_state <= c_st_decode;
                c_st_decode: begin
                    r_cls   <= instr_class;
                    r_state <= (instr_class == c_cls_halt) ? c_st_halted : c_st_execute;
                end
                c_st_execute: begin
                    case (r_cls)
                        c_cls_alu_reg, c_cls_alu_imm: r_state <= c_st_wb;
                        c_cls_load, c_cls_store: begin
                            r_state <= c_st_mem;
                            r_wait  <= 8'd0;
                        end
                        default: ;
                    endcase
                end
                c_st_mem: begin
                    if (mem_ready) begin
                        if (r_cls == c_cls_load) r_state <= c_st_wb;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (r_wait + 8'd1 == c_timeout) r_state <= c_st_fault;
                    end
                end
                default: ;
            endcase

            // Every retire funnels through pc_en; stop is only honoured here.
            if (pc_en) begin
                r_retired <= r_retired + CNT_W'(1);
                r_state   <= stop ? c_st_idle : c_st_fetch;
            end
        end
    end

    assign phase   = r_state;
    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
// ============================================================================
// Module   : tb_cpu_phase_sequencer
// Brief    : Table-driven, scoreboarded bench for cpu_phase_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_phase_sequencer;

    logic        clk = 1'b0;
    logic        PRS, start, stop, mem_ready;
    logic [2:0]  instr_class;
    logic [2:0]  phase, phase_s;
    logic        ir_load, pc_en, pc_src, imm_sel, rf_we, ram_re, ram_we, halted, fault;
    logic        ir_load_s, pc_en_s, pc_src_s, imm_sel_s, rf_we_s, ram_re_s, ram_we_s, halted_s, fault_s;
    logic [19:0] retired;
    logic [2:0]  retired_s;
    logic [8:0]  outs, outs_s;

    always #5 clk = ~clk;

    cpu_phase_sequencer #(.MEM_TIMEOUT(15), .CNT_W(20)) dut (
        .clk(clk), .PRS(PRS), .start(start), .stop(stop), .instr_class(instr_class),
        .mem_ready(mem_ready), .phase(phase), .ir_load(ir_load), .pc_en(pc_en),
        .pc_src(pc_src), .imm_sel(imm_sel), .rf_we(rf_we), .ram_re(ram_re),
        .ram_we(ram_we), .halted(halted), .fault(fault), .retired(retired)
    );

    // Narrow-counter twin sharing all inputs, so the counter wrap is reachable quickly.
    cpu_phase_sequencer #(.MEM_TIMEOUT(15), .CNT_W(3)) dut_wrap (
        .clk(clk), .PRS(PRS), .start(start), .stop(stop), .instr_class(instr_class),
        .mem_ready(mem_ready), .phase(phase_s), .ir_load(ir_load_s), .pc_en(pc_en_s),
        .pc_src(pc_src_s), .imm_sel(imm_sel_s), .rf_we(rf_we_s), .ram_re(ram_re_s),
        .ram_we(ram_we_s), .halted(halted_s), .fault(fault_s), .retired(retired_s)
    );

    assign outs   = {ir_load, pc_en, pc_src, imm_sel, rf_we, ram_re, ram_we, halted, fault};
    assign outs_s = {ir_load_s, pc_en_s, pc_src_s, imm_sel_s, rf_we_s, ram_re_s, ram_we_s, halted_s, fault_s};

    typedef struct {
        logic [2:0] cls;
        int         w;
        bit         stp;
        int         cyc;
        int         n_re;
        int         n_we;
        int         n_rf;
        int         n_src;
        int         n_imm;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   exp_ret = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] c, input int w, input bit s, input int cy,
                                input int re, input int we, input int rf, input int src,
                                input int imm);
        vec_t v;
        v.cls = c; v.w = w; v.stp = s; v.cyc = cy;
        v.n_re = re; v.n_we = we; v.n_rf = rf; v.n_src = src; v.n_imm = imm;
        return v;
    endfunction

    // Entered at a falling edge with the DUT in FETCH; returns at a falling edge after retire.
    task automatic run_instr(input vec_t v);
        vec_t e;
        int   cyc = 0, memc = 0, n_ir = 0, n_rf = 0, n_re = 0, n_we = 0, n_src = 0, n_imm = 0;
        bit   done = 1'b0, bad = 1'b0, diff = 1'b0;
        exp_q.push_back(v);
        for (int i = 0; i < 40 && !done; i++) begin
            instr_class = (phase == 3'd2) ? v.cls : 3'($urandom_range(0, 7));
            mem_ready   = (phase == 3'd4) ? (memc >= v.w) : 1'($urandom_range(0, 1));
            stop        = v.stp;
            #1;
            cyc++;
            n_ir  += int'(ir_load);
            n_rf  += int'(rf_we);
            n_re  += int'(ram_re);
            n_we  += int'(ram_we);
            n_src += int'(pc_src);
            n_imm += int'(imm_sel);
            if ((ram_re && ram_we) || (rf_we && ram_we)) bad = 1'b1;
            if (outs_s != outs || phase_s != phase) diff = 1'b1;
            if (phase == 3'd4) memc++;
            if (pc_en) done = 1'b1;
            else @(negedge clk);
        end
        check("retire_seen", longint'(done), 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("latency", cyc, e.cyc);
            check("ir_load_cycles", n_ir, 1);
            check("rf_we_cycles", n_rf, e.n_rf);
            check("ram_re_cycles", n_re, e.n_re);
            check("ram_we_cycles", n_we, e.n_we);
            check("pc_src_cycles", n_src, e.n_src);
            check("imm_sel_cycles", n_imm, e.n_imm);
            check("strobe_exclusive", longint'(bad), 0);
            check("twin_agree", longint'(diff), 0);
            if (done) exp_ret++;
        end
        @(negedge clk);
        stop = 1'b0;
        check("retired", retired, exp_ret % (1 << 20));
        check("retired_wrap", retired_s, exp_ret % 8);
    endtask

    initial begin
        int memc, n_re;
        vecs[0] = mk(3'd0, 0, 1'b0, 3, 0, 0, 0, 0, 0);
        vecs[1] = mk(3'd6, 0, 1'b0, 3, 0, 0, 0, 0, 0);
        vecs[2] = mk(3'd2, 0, 1'b0, 4, 0, 0, 1, 0, 2);
        vecs[3] = mk(3'd1, 0, 1'b0, 4, 0, 0, 1, 0, 0);
        vecs[4] = mk(3'd5, 0, 1'b0, 3, 0, 0, 0, 1, 0);
        vecs[5] = mk(3'd3, 2, 1'b0, 7, 3, 0, 1, 0, 0);
        vecs[6] = mk(3'd4, 0, 1'b0, 4, 0, 1, 0, 0, 0);
        vecs[7] = mk(3'd3, 0, 1'b0, 5, 1, 0, 1, 0, 0);
        vecs[8] = mk(3'd4, 3, 1'b0, 7, 0, 4, 0, 0, 0);
        vecs[9] = mk(3'd1, 0, 1'b1, 4, 0, 0, 1, 0, 0);

        PRS = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b0; instr_class = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", outs, 0);
        check("reset_phase", phase, 0);
        check("reset_retired", retired, 0);

        @(negedge clk);
        PRS = 1'b0; start = 1'b1;
        @(negedge clk);
        check("start_fetch", phase, 1);

        foreach (vecs[i]) run_instr(vecs[i]);

        // Stop retire drops to IDLE; held start re-enters FETCH after one cycle.
        check("stop_idle", phase, 0);
        @(negedge clk);
        check("idle_dwell_fetch", phase, 1);

        // LOAD starved of mem_ready must fault after the timeout window.
        start = 1'b0; instr_class = 3'd3; mem_ready = 1'b0;
        memc = 0; n_re = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (phase == 3'd7) break;
            if (phase == 3'd4) memc++;
            n_re += int'(ram_re);
            @(negedge clk);
        end
        check("timeout_mem_cycles", memc, 15);
        check("timeout_ram_re", n_re, 15);
        check("fault_flag", fault, 1);
        check("fault_retired", retired, exp_ret);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start; stop = ~stop; mem_ready = ~mem_ready;
        end
        #1;
        check("fault_sticky", phase, 7);
        check("fault_outs", outs, 9'b0_0000_0001);

        PRS = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        #1;
        check("fault_reset_phase", phase, 0);
        check("fault_reset_outs", outs, 0);
        exp_ret = 0;

        // Two ALU_REG then HALT.
        @(negedge clk);
        PRS = 1'b0; start = 1'b1;
        @(negedge clk);
        check("restart_fetch", phase, 1);
        run_instr(vecs[3]);
        run_instr(vecs[3]);
        instr_class = 3'd7;
        @(negedge clk);
        check("halt_decode", phase, 2);
        @(negedge clk);
        check("halted_flag", halted, 1);
        check("halted_retired", retired, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start; stop = ~stop;
        end
        #1;
        check("halt_sticky", phase, 6);
        check("halt_outs", outs, 9'b0_0000_0010);
        PRS = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        #1;
        check("halt_reset_outs", outs, 0);
        check("halt_reset_retired", retired, 0);

        // Reset while a LOAD is waiting in MEM.
        @(negedge clk);
        PRS = 1'b0; start = 1'b1; instr_class = 3'd3; mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mem_ram_re", ram_re, 1);
        @(negedge clk);
        PRS = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        check("mem_reset_ram_re", ram_re, 0);
        check("mem_reset_phase", phase, 0);
        check("mem_reset_retired", retired, 0);
        PRS = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
